// File: rtl/rob_retire.sv
// In-order retire queue: dispatch pushes tags, the CDB marks entries done in any order,
// and the head entry retires onto the Retire BUS one per cycle, strictly in push order.
module rob_retire #(
    parameter int DSIZE = 5,
    parameter int ASIZE = 5,
    parameter int WSIZE = 32,
    parameter int RSIZE = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             Dispatch_en,
    input  logic [DSIZE-1:0] Dispatch_Tag,
    input  logic [RSIZE-1:0] Dispatch_Rd,
    input  logic             CDB_Valid,
    input  logic [DSIZE-1:0] CDB_Tag,
    input  logic [WSIZE-1:0] CDB_Data,
    output logic             RB_Tag_Valid,
    output logic [DSIZE-1:0] RB_Tag,
    output logic [RSIZE-1:0] RB_Rd,
    output logic [WSIZE-1:0] RB_Data,
    output logic             Rob_full,
    output logic             Rob_empty
);

    localparam int unsigned DEPTH = 1 << ASIZE;

    logic [ASIZE:0]   wptr, rptr;
    logic [ASIZE-1:0] widx, ridx;
    logic [DEPTH-1:0] ent_valid, ent_done;
    logic [DSIZE-1:0] ent_tag  [DEPTH];
    logic [RSIZE-1:0] ent_rd   [DEPTH];
    logic [WSIZE-1:0] ent_data [DEPTH];
    logic [DEPTH-1:0] cdb_hit;
    logic             push, retire;

    always_comb begin
        widx      = wptr[ASIZE-1:0];
        ridx      = rptr[ASIZE-1:0];
        Rob_empty = (wptr == rptr);
        Rob_full  = (wptr[ASIZE] != rptr[ASIZE]) && (widx == ridx);
        push      = Dispatch_en && !Rob_full;
        retire    = ent_valid[ridx] && ent_done[ridx];
    end

    // Only pre-edge valid, not-done entries can match, so a same-edge push is never completed.
    always_comb begin
        cdb_hit = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            cdb_hit[i[ASIZE-1:0]] = CDB_Valid && ent_valid[i[ASIZE-1:0]] &&
                                    !ent_done[i[ASIZE-1:0]] &&
                                    (ent_tag[i[ASIZE-1:0]] == CDB_Tag);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr         <= '0;
            rptr         <= '0;
            ent_valid    <= '0;
            ent_done     <= '0;
            RB_Tag_Valid <= 1'b0;
            RB_Tag       <= '0;
            RB_Rd        <= '0;
            RB_Data      <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_tag[i[ASIZE-1:0]]  <= '0;
                ent_rd[i[ASIZE-1:0]]   <= '0;
                ent_data[i[ASIZE-1:0]] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (cdb_hit[i[ASIZE-1:0]]) begin
                    ent_done[i[ASIZE-1:0]] <= 1'b1;
                    ent_data[i[ASIZE-1:0]] <= CDB_Data;
                end
            end
            RB_Tag_Valid <= retire;
            if (retire) begin
                RB_Tag          <= ent_tag[ridx];
                RB_Rd           <= ent_rd[ridx];
                RB_Data         <= ent_data[ridx];
                ent_valid[ridx] <= 1'b0;
                ent_done[ridx]  <= 1'b0;
                rptr            <= rptr + 1'b1;
            end
            // Push slot never equals the retiring or a completing slot: push requires !full.
            if (push) begin
                ent_valid[widx] <= 1'b1;
                ent_done[widx]  <= 1'b0;
                ent_tag[widx]   <= Dispatch_Tag;
                ent_rd[widx]    <= Dispatch_Rd;
                ent_data[widx]  <= '0;
                wptr            <= wptr + 1'b1;
            end
        end
    end

endmodule
